// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC,
// trap opcode, FSM state type and queue entry layout.
// Optional feature macro: IF_HALT_ON_TRAP_EN (adds the HALT state).
package if_stage_pkg;

    localparam int unsigned REG_BUS  = 64;
    localparam int unsigned INST_BUS = 32;

    localparam logic [REG_BUS-1:0] IF_RESET_PC = 64'h8000_0000;
    localparam logic [6:0]         OPCODE_TRAP = 7'h6b;

    typedef enum logic [1:0] {
        IF_S_IDLE = 2'd0,
        IF_S_REQ  = 2'd1,
        IF_S_WAIT = 2'd2
`ifdef IF_HALT_ON_TRAP_EN
        ,
        IF_S_HALT = 2'd3
`endif
    } if_state_e;

    typedef struct packed {
        logic [INST_BUS-1:0] inst;
        logic [REG_BUS-1:0]  pc;
    } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// Two-entry instruction queue between fetch and decode. Flush empties it in
// one cycle and wins over a simultaneous push or pop. Head reads as zero
// while empty.
module if_queue
    import if_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  if_entry_t push_data_i,
    output logic [1:0] count_o,
    output logic      valid_o,
    output if_entry_t head_o
);

    if_entry_t  mem_q [2];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) wptr_q <= ~wptr_q;
            if (do_pop)  rptr_q <= ~rptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word
// fetches and feeds the 2-entry queue toward decode. Redirects flush the
// queue and kill any in-flight response.
// Optional feature macro: IF_HALT_ON_TRAP_EN (stop fetching after a trap
// opcode is queued until reset or redirect).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [REG_BUS-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [REG_BUS-1:0]  redirect_pc,
    output logic                ibus_req_valid,
    input  logic                ibus_req_ready,
    output logic [REG_BUS-1:0]  ibus_req_addr,
    input  logic                ibus_resp_valid,
    input  logic [INST_BUS-1:0] ibus_resp_data,
    output logic                if_valid,
    input  logic                id_ready,
    output logic [INST_BUS-1:0] inst,
    output logic [REG_BUS-1:0]  inst_addr
);

    if_state_e          state_q, state_d;
    logic [REG_BUS-1:0] pc_q, pc_d;
    logic [REG_BUS-1:0] req_pc_q, req_pc_d;
    logic               kill_q, kill_d;
    logic               req_valid;
    logic               push;
    logic [1:0]         q_count;
    logic               q_valid;
    if_entry_t          q_head;
    if_entry_t          push_data;
    logic [REG_BUS-1:0] redir_pc;

    assign redir_pc  = redirect_pc & ~REG_BUS'(3);
    assign push_data = '{inst: ibus_resp_data, pc: req_pc_q};

    // FSM, PC and kill state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IF_S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
        end
    end

    // Next-state, request issue and push decisions; redirect overrides last.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        kill_d    = kill_q;
        req_valid = 1'b0;
        push      = 1'b0;

        case (state_q)
            IF_S_IDLE: state_d = IF_S_REQ;
            IF_S_REQ: begin
                // Nothing is outstanding in REQ, so only queue occupancy matters.
                req_valid = (q_count < 2'd2);
                if (req_valid && ibus_req_ready) begin
                    state_d  = IF_S_WAIT;
                    pc_d     = pc_q + REG_BUS'(4);
                    req_pc_d = pc_q;
                end
            end
            IF_S_WAIT: begin
                if (ibus_resp_valid) begin
                    state_d = IF_S_REQ;
                    kill_d  = 1'b0;
                    push    = !kill_q;
`ifdef IF_HALT_ON_TRAP_EN
                    if (!kill_q && (ibus_resp_data[6:0] == OPCODE_TRAP)) begin
                        state_d = IF_S_HALT;
                    end
`endif
                end
            end
`ifdef IF_HALT_ON_TRAP_EN
            IF_S_HALT: state_d = IF_S_HALT;
`endif
            default: state_d = IF_S_IDLE;
        endcase

        if (redirect_valid) begin
            push = 1'b0;
            pc_d = redir_pc;
            if (state_q == IF_S_WAIT) begin
                // A response arriving with the redirect is simply consumed;
                // otherwise the one still in flight must be dropped later.
                kill_d  = !ibus_resp_valid;
                state_d = ibus_resp_valid ? IF_S_REQ : IF_S_WAIT;
            end else if (req_valid && ibus_req_ready) begin
                state_d = IF_S_WAIT;
                kill_d  = 1'b1;
            end else begin
                state_d = IF_S_REQ;
                kill_d  = 1'b0;
            end
        end
    end

    if_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (q_valid && id_ready),
        .flush_i     (redirect_valid),
        .push_data_i (push_data),
        .count_o     (q_count),
        .valid_o     (q_valid),
        .head_o      (q_head)
    );

    assign ibus_req_valid = req_valid;
    assign ibus_req_addr  = req_valid ? pc_q : '0;
    assign if_valid       = q_valid;
    assign inst           = q_head.inst;
    assign inst_addr      = q_head.pc;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        ibus_req_valid;
    logic        ibus_req_ready = 1'b0;
    logic [63:0] ibus_req_addr;
    logic        ibus_resp_valid = 1'b0;
    logic [31:0] ibus_resp_data = '0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .ibus_req_valid  (ibus_req_valid),
        .ibus_req_ready  (ibus_req_ready),
        .ibus_req_addr   (ibus_req_addr),
        .ibus_resp_valid (ibus_resp_valid),
        .ibus_resp_data  (ibus_resp_data),
        .if_valid        (if_valid),
        .id_ready        (id_ready),
        .inst            (inst),
        .inst_addr       (inst_addr)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[26:2], 7'h13};
    endfunction

    // Reference model: expected queue contents and expected address streams.
    typedef struct { logic [31:0] d; logic [63:0] a; } ent_t;
    ent_t        q[$];
    logic [63:0] exp_req_pc = RST_PC;
    logic [63:0] exp_dec_pc = RST_PC;
    bit          pend = 0, pend_live = 0;
    int unsigned pend_dly = 0;
    logic [63:0] pend_addr = '0;
    bit          prev_hold = 0, prev_redir = 0;
    logic [63:0] prev_addr = '0;
    int unsigned p_redir = 0, p_ready = 100, p_idr = 100, max_lat = 0;
    int unsigned stall = 0, n_pops = 0, cyc = 0;

    task automatic run(input int unsigned n);
        logic [63:0] rpc;
        bit hs, pop;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            rpc = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                           : RST_PC + 64'($urandom_range(255)) * 64'd4;
            redirect_valid  = ($urandom_range(99) < p_redir);
            redirect_pc     = rpc | 64'($urandom_range(3));
            ibus_req_ready  = ($urandom_range(99) < p_ready);
            id_ready        = ($urandom_range(99) < p_idr);
            ibus_resp_valid = pend && (pend_dly == 0);
            ibus_resp_data  = (ibus_resp_valid && pend_live) ? mem_word(pend_addr) : 32'hDEAD_BEEF;
            #1;
            if (cyc == 0) begin
                check_eq("first_req_valid", ibus_req_valid, 1'b1);
                check_eq("first_req_addr", ibus_req_addr, RST_PC);
            end
            check_eq("if_valid", if_valid, q.size() != 0);
            check_eq("inst", inst, (q.size() != 0) ? q[0].d : 32'h0);
            check_eq("inst_addr", inst_addr, (q.size() != 0) ? q[0].a : 64'h0);
            if (prev_redir) check_eq("valid_after_redirect", if_valid, 1'b0);
            if (prev_hold) begin
                check_eq("req_hold_valid", ibus_req_valid, 1'b1);
                check_eq("req_hold_addr", ibus_req_addr, prev_addr);
            end
            if (ibus_req_valid) begin
                check_eq("one_outstanding", pend, 1'b0);
                check_eq("issue_room", q.size() < 2, 1'b1);
            end
            hs  = ibus_req_valid && ibus_req_ready;
            pop = if_valid && id_ready;
            if (pop && !redirect_valid) begin
                check_eq("dec_order", inst_addr, exp_dec_pc);
                exp_dec_pc += 64'd4;
                n_pops++;
            end
            if (hs) check_eq("req_addr", ibus_req_addr, exp_req_pc);
            if (hs || pop) stall = 0; else stall++;
            check_eq("no_stall", stall <= 60, 1'b1);

            if (redirect_valid) begin
                q.delete();
                exp_req_pc = rpc;
                exp_dec_pc = rpc;
                pend_live  = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (ibus_resp_valid && pend_live) q.push_back('{mem_word(pend_addr), pend_addr});
                if (hs) exp_req_pc += 64'd4;
            end
            if (ibus_resp_valid) pend = 0;
            else if (pend) pend_dly--;
            if (hs) begin
                pend      = 1;
                pend_live = !redirect_valid;
                pend_addr = ibus_req_addr;
                pend_dly  = $urandom_range(max_lat);
            end
            prev_hold  = ibus_req_valid && !ibus_req_ready && !redirect_valid;
            prev_addr  = ibus_req_addr;
            prev_redir = redirect_valid;
            cyc++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_addr", inst_addr, 64'h0);
        check_eq("rst_req_valid", ibus_req_valid, 1'b0);
        check_eq("rst_req_addr", ibus_req_addr, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_no_req", ibus_req_valid, 1'b0);

        // Always-ready bus with 1-cycle responses: one instruction per 2 cycles.
        run(20);
        check_eq("throughput", n_pops, 9);

        // Decode stalled: queue saturates and requests stop.
        p_idr = 0;
        run(12);
        check_eq("full_valid", if_valid, 1'b1);
        check_eq("full_no_req", ibus_req_valid, 1'b0);
        p_idr = 100;
        run(4);

        // Randomized traffic with redirects and variable latency.
        p_redir = 8; p_ready = 70; p_idr = 70; max_lat = 3;
        run(3000);

        // Request held while the bus is not ready.
        p_redir = 0; p_ready = 0;
        run(6);
        p_ready = 100;
        run(4);

        // Reset in the middle of a transaction; a late response is ignored.
        max_lat = 3;
        for (int k = 0; k < 20 && !pend; k++) run(1);
        check_eq("pending_before_reset", pend, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        ibus_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_eq("midrst_if_valid", if_valid, 1'b0);
        check_eq("midrst_req_valid", ibus_req_valid, 1'b0);
        check_eq("midrst_inst_addr", inst_addr, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ibus_req_ready  = 1'b0;
        ibus_resp_valid = 1'b1;
        ibus_resp_data  = 32'h0000_0013;
        @(negedge clk);
        check_eq("late_resp_idle_req", ibus_req_valid, 1'b0);
        @(negedge clk);
        check_eq("late_resp_dropped", if_valid, 1'b0);
        check_eq("post_rst_req", ibus_req_valid, 1'b1);
        check_eq("post_rst_addr", ibus_req_addr, RST_PC);
        @(negedge clk);
        ibus_resp_valid = 1'b0;
        check_eq("late_resp_in_req", if_valid, 1'b0);

        check_eq("progress", n_pops > 200, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
